// File: rtl/pcpi_pkg.sv
// Shared types and instruction-field constants for the PCPI dispatcher.
// The claim function is the single place that defines which words are ours.
package pcpi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2,
    DRAIN = 2'd3
  } state_e;

  localparam logic [6:0] OPCODE_CUSTOM0 = 7'b0001011;

  localparam int OPC_LSB  = 0;
  localparam int OPC_MSB  = 6;
  localparam int USEL_LSB = 25;
  localparam int USEL_MSB = 26;
  localparam int RSV_LSB  = 27;
  localparam int RSV_MSB  = 31;

  function automatic logic insn_claimed(input logic [31:0] insn,
                                        input logic [6:0]  opcode,
                                        input int          num_units);
    return (insn[OPC_MSB:OPC_LSB] == opcode) &&
           (insn[RSV_MSB:RSV_LSB] == '0) &&
           (int'(insn[USEL_MSB:USEL_LSB]) < num_units);
  endfunction

endpackage

// File: rtl/pcpi_watchdog.sv
// Issue watchdog: counts cycles since clear while enabled, flags the last
// allowed cycle so the dispatcher can force a response on the next edge.
module pcpi_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  // One extra count of headroom: the counter may step once past TIMEOUT-1
  // on the edge where the dispatcher leaves ISSUE.
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/pcpi_dispatch.sv
// PCPI front end: claims custom-0 words, forwards them to one attached unit,
// holds pcpi_wait while it works and returns its result or a watchdog abort.
module pcpi_dispatch
  import pcpi_pkg::*;
#(
  parameter int         NUM_UNITS = 4,
  parameter logic [6:0] OPCODE    = OPCODE_CUSTOM0,
  parameter int         TIMEOUT   = 64
) (
  input  logic                    pcpi_clock,
  input  logic                    pcpi_reset,
  input  logic                    pcpi_valid,
  input  logic [31:0]             pcpi_insn,
  input  logic [31:0]             pcpi_rs1,
  input  logic [31:0]             pcpi_rs2,
  output logic                    pcpi_wait,
  output logic                    pcpi_ready,
  output logic                    pcpi_wr,
  output logic [31:0]             pcpi_rd,
  output logic [NUM_UNITS-1:0]    u_valid,
  output logic [31:0]             u_insn,
  output logic [31:0]             u_rs1,
  output logic [31:0]             u_rs2,
  input  logic [NUM_UNITS-1:0]    u_ready,
  input  logic [NUM_UNITS-1:0]    u_wr,
  input  logic [32*NUM_UNITS-1:0] u_rd,
  output logic                    busy,
  output logic                    timeout_err
);

  state_e                 state_q;
  logic [1:0]             idx_q;
  logic [NUM_UNITS-1:0]   u_valid_q;
  logic [31:0]            insn_q;
  logic [31:0]            rs1_q;
  logic [31:0]            rs2_q;
  logic [31:0]            rd_q;
  logic                   wr_q;
  logic                   ready_q;
  logic                   wait_q;
  logic                   terr_q;

  logic                   claim_d;
  logic [1:0]             sel_d;
  logic [NUM_UNITS-1:0]   u_valid_d;
  logic                   sel_ready;
  logic                   sel_wr;
  logic [31:0]            sel_rd;
  logic                   accept;
  logic                   wd_en;
  logic                   wd_expired;

  assign claim_d = insn_claimed(pcpi_insn, OPCODE, NUM_UNITS);
  assign sel_d   = pcpi_insn[USEL_MSB:USEL_LSB];
  assign accept  = (state_q == IDLE) && pcpi_valid && claim_d;
  assign wd_en   = (state_q == ISSUE);

  always_comb begin
    u_valid_d = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (sel_d == 2'(i)) u_valid_d[i] = 1'b1;
    end
  end

  // Only the latched unit's handshake is visible; others are ignored.
  always_comb begin
    sel_ready = 1'b0;
    sel_wr    = 1'b0;
    sel_rd    = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (idx_q == 2'(i)) begin
        sel_ready = u_ready[i];
        sel_wr    = u_wr[i];
        sel_rd    = u_rd[32*i +: 32];
      end
    end
  end

  pcpi_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk_i     (pcpi_clock),
    .rst_ni    (pcpi_reset),
    .clr_i     (accept),
    .en_i      (wd_en),
    .expired_o (wd_expired)
  );

  always_ff @(posedge pcpi_clock or negedge pcpi_reset) begin
    if (!pcpi_reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      u_valid_q <= '0;
      insn_q    <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_q      <= '0;
      wr_q      <= 1'b0;
      ready_q   <= 1'b0;
      wait_q    <= 1'b0;
      terr_q    <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            idx_q     <= sel_d;
            insn_q    <= pcpi_insn;
            rs1_q     <= pcpi_rs1;
            rs2_q     <= pcpi_rs2;
            u_valid_q <= u_valid_d;
            wait_q    <= 1'b1;
            state_q   <= ISSUE;
          end
        end
        ISSUE: begin
          // Flush beats completion: the core no longer wants the result.
          if (!pcpi_valid) begin
            u_valid_q <= '0;
            wait_q    <= 1'b0;
            state_q   <= IDLE;
          end else if (sel_ready) begin
            rd_q      <= sel_rd;
            wr_q      <= sel_wr;
            u_valid_q <= '0;
            wait_q    <= 1'b0;
            ready_q   <= 1'b1;
            state_q   <= RESP;
          end else if (wd_expired) begin
            rd_q      <= '0;
            wr_q      <= 1'b0;
            u_valid_q <= '0;
            wait_q    <= 1'b0;
            ready_q   <= 1'b1;
            terr_q    <= 1'b1;
            state_q   <= RESP;
          end
        end
        RESP: begin
          state_q <= DRAIN;
        end
        DRAIN: begin
          if (!pcpi_valid) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign pcpi_wait   = wait_q;
  assign pcpi_ready  = ready_q;
  assign pcpi_wr     = wr_q;
  assign pcpi_rd     = rd_q;
  assign u_valid     = u_valid_q;
  assign u_insn      = insn_q;
  assign u_rs1       = rs1_q;
  assign u_rs2       = rs2_q;
  assign busy        = (state_q != IDLE);
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_pcpi_dispatch.sv
// Bench for pcpi_dispatch: vector table drives full transactions, a scoreboard
// matches each pcpi_ready against the result queued when the request went out.
module tb_pcpi_dispatch;

  localparam int NU      = 4;
  localparam int TIMEOUT = 64;

  logic            pcpi_clock = 1'b0;
  logic            pcpi_reset;
  logic            pcpi_valid;
  logic [31:0]     pcpi_insn;
  logic [31:0]     pcpi_rs1;
  logic [31:0]     pcpi_rs2;
  logic            pcpi_wait;
  logic            pcpi_ready;
  logic            pcpi_wr;
  logic [31:0]     pcpi_rd;
  logic [NU-1:0]   u_valid;
  logic [31:0]     u_insn;
  logic [31:0]     u_rs1;
  logic [31:0]     u_rs2;
  logic [NU-1:0]   u_ready;
  logic [NU-1:0]   u_wr;
  logic [32*NU-1:0] u_rd;
  logic            busy;
  logic            timeout_err;

  int checks   = 0;
  int failures = 0;

  logic [32:0] sb_q[$];
  logic [32:0] sb_exp;

  typedef struct {
    logic [31:0] insn;
    logic [31:0] rs1;
    logic [31:0] rs2;
    int          delay;     // cycle of u_ready; 0 = unit never answers
    logic        wr;
    logic [31:0] rd;
    bit          claim;
    logic        exp_wr;
    logic [31:0] exp_rd;
    logic        exp_terr;
  } vec_t;

  vec_t vecs[9];

  always #5 pcpi_clock = ~pcpi_clock;

  pcpi_dispatch #(
    .NUM_UNITS (NU),
    .OPCODE    (7'b0001011),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .pcpi_clock  (pcpi_clock),
    .pcpi_reset  (pcpi_reset),
    .pcpi_valid  (pcpi_valid),
    .pcpi_insn   (pcpi_insn),
    .pcpi_rs1    (pcpi_rs1),
    .pcpi_rs2    (pcpi_rs2),
    .pcpi_wait   (pcpi_wait),
    .pcpi_ready  (pcpi_ready),
    .pcpi_wr     (pcpi_wr),
    .pcpi_rd     (pcpi_rd),
    .u_valid     (u_valid),
    .u_insn      (u_insn),
    .u_rs1       (u_rs1),
    .u_rs2       (u_rs2),
    .u_ready     (u_ready),
    .u_wr        (u_wr),
    .u_rd        (u_rd),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every completion pulse must match the oldest queued result.
  always @(negedge pcpi_clock) begin
    if (pcpi_reset && pcpi_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_ready: got pcpi_ready=1 expected no response at %0t", $time);
      end else begin
        sb_exp = sb_q.pop_front();
        check("resp_rd", 64'(pcpi_rd), 64'(sb_exp[31:0]));
        check("resp_wr", 64'(pcpi_wr), 64'(sb_exp[32]));
      end
    end
  end

  task automatic run_txn(input int id, input vec_t v);
    logic [NU-1:0] oh;
    int            unit;
    int            exit_c;
    unit   = int'(v.insn[26:25]);
    oh     = NU'(1) << unit;
    exit_c = (v.delay >= 1 && v.delay <= TIMEOUT) ? v.delay : TIMEOUT;

    @(posedge pcpi_clock); #1;
    pcpi_valid = 1'b1;
    pcpi_insn  = v.insn;
    pcpi_rs1   = v.rs1;
    pcpi_rs2   = v.rs2;
    u_rd       = '0;
    u_rd[32*unit +: 32] = v.rd;
    u_wr       = v.wr ? oh : '0;

    if (!v.claim) begin
      for (int c = 0; c < 20; c++) begin
        @(negedge pcpi_clock);
        check($sformatf("v%0d_unclaimed", id),
              64'({u_valid, pcpi_wait, pcpi_ready, busy}), 64'(0));
      end
      @(posedge pcpi_clock); #1;
      pcpi_valid = 1'b0;
      @(negedge pcpi_clock);
      check($sformatf("v%0d_terr", id), 64'(timeout_err), 64'(v.exp_terr));
      return;
    end

    sb_q.push_back({v.exp_wr, v.exp_rd});

    for (int c = 1; c <= exit_c + 1; c++) begin
      @(posedge pcpi_clock); #1;
      // Other units pulse u_ready early; the dispatcher must ignore them.
      if (c == v.delay)  u_ready = oh;
      else if (c == 1)   u_ready = ~oh;
      else               u_ready = '0;
      @(negedge pcpi_clock);
      if (c <= exit_c) begin
        check($sformatf("v%0d_issue_c%0d", id, c),
              64'({u_valid, pcpi_wait, pcpi_ready, busy}), 64'({oh, 1'b1, 1'b0, 1'b1}));
        if (c == 1) begin
          check($sformatf("v%0d_u_ops", id), {u_insn, u_rs1 ^ u_rs2},
                {v.insn, v.rs1 ^ v.rs2});
        end
      end else begin
        check($sformatf("v%0d_resp", id),
              64'({u_valid, pcpi_wait, pcpi_ready, busy}), 64'({{NU{1'b0}}, 1'b0, 1'b1, 1'b1}));
      end
    end

    @(posedge pcpi_clock); #1;
    u_ready = '0;
    @(negedge pcpi_clock);
    check($sformatf("v%0d_drain", id),
          64'({u_valid, pcpi_wait, pcpi_ready, busy}), 64'({{NU{1'b0}}, 1'b0, 1'b0, 1'b1}));
    check($sformatf("v%0d_hold", id), 64'({pcpi_wr, pcpi_rd}), 64'({v.exp_wr, v.exp_rd}));
    @(posedge pcpi_clock); #1;
    pcpi_valid = 1'b0;
    @(negedge pcpi_clock);
    @(negedge pcpi_clock);
    check($sformatf("v%0d_idle", id), 64'({busy, pcpi_ready}), 64'(0));
    check($sformatf("v%0d_terr", id), 64'(timeout_err), 64'(v.exp_terr));
  endtask

  initial begin
    vec_t post;

    vecs[0] = '{32'h0200000B, 32'd5, 32'd7, 4, 1'b1, 32'hC, 1'b1, 1'b1, 32'hC, 1'b0};
    vecs[1] = '{32'h0000003B, 32'd1, 32'd2, 0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0};
    vecs[2] = '{32'h4000000B, 32'd1, 32'd2, 0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0};
    vecs[3] = '{32'h0000000B, 32'd1, 32'd2, 1, 1'b0, 32'h1234, 1'b1, 1'b0, 32'h1234, 1'b0};
    vecs[4] = '{32'h0600000B, 32'd3, 32'd4, 2, 1'b1, 32'hDEADBEEF, 1'b1, 1'b1, 32'hDEADBEEF, 1'b0};
    vecs[5] = '{32'h0400000B, 32'd8, 32'd9, TIMEOUT, 1'b1, 32'hA5A5, 1'b1, 1'b1, 32'hA5A5, 1'b0};
    vecs[6] = '{32'h0400000B, 32'd10, 32'd11, 0, 1'b1, 32'h5555, 1'b1, 1'b0, 32'h0, 1'b1};
    vecs[7] = '{32'h03FFF00B, 32'd1, 32'd1, 3, 1'b1, 32'h77, 1'b1, 1'b1, 32'h77, 1'b1};
    vecs[8] = '{32'h0800000B, 32'd0, 32'd0, 0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1};

    pcpi_reset = 1'b0;
    pcpi_valid = 1'b0;
    pcpi_insn  = '0;
    pcpi_rs1   = '0;
    pcpi_rs2   = '0;
    u_ready    = '0;
    u_wr       = '0;
    u_rd       = '0;
    #12;
    check("reset_ctrl", 64'({u_valid, pcpi_wait, pcpi_ready, pcpi_wr, busy, timeout_err}), 64'(0));
    check("reset_data", {pcpi_rd, u_insn}, 64'(0));
    check("reset_ops", {u_rs1, u_rs2}, 64'(0));
    @(posedge pcpi_clock); #1;
    pcpi_reset = 1'b1;

    for (int i = 0; i < 9; i++) run_txn(i, vecs[i]);

    // Reset in the middle of ISSUE; the unit's late answer must be dropped.
    @(posedge pcpi_clock); #1;
    pcpi_valid = 1'b1;
    pcpi_insn  = 32'h0400000B;
    pcpi_rs1   = 32'd3;
    pcpi_rs2   = 32'd4;
    for (int c = 1; c <= 3; c++) begin
      @(posedge pcpi_clock); #1;
    end
    @(negedge pcpi_clock);
    check("rst_mid_issue", 64'({u_valid, busy}), 64'({4'b0100, 1'b1}));
    #1;
    pcpi_reset = 1'b0;
    pcpi_valid = 1'b0;
    #1;
    check("rst_mid_ctrl", 64'({u_valid, pcpi_wait, pcpi_ready, pcpi_wr, busy, timeout_err}), 64'(0));
    check("rst_mid_data", {pcpi_rd, u_insn}, 64'(0));
    #1;
    pcpi_reset = 1'b1;
    @(posedge pcpi_clock); #1;
    u_ready = 4'b0100;
    u_wr    = 4'b0100;
    u_rd    = '0;
    u_rd[64 +: 32] = 32'h99;
    for (int c = 0; c < 3; c++) begin
      @(negedge pcpi_clock);
      check($sformatf("rst_late_ready_%0d", c), 64'({u_valid, pcpi_ready, busy}), 64'(0));
      @(posedge pcpi_clock); #1;
      u_ready = '0;
    end

    post = '{32'h0000000B, 32'd21, 32'd22, 2, 1'b1, 32'hCAFE, 1'b1, 1'b1, 32'hCAFE, 1'b0};
    run_txn(9, post);

    repeat (3) @(negedge pcpi_clock);
    check("sb_empty", 64'(sb_q.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
